// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer.
// Ports: cmd_* command in, rsp_* completion pulse out, p* APB bus.
module apb_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic                    pwakeup,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [SW-1:0]         r_pstrb;
  logic [2:0]            r_pprot;
  logic [CW-1:0]         r_wait;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_tmo;

  logic w_idle;
  logic w_accept;
  logic w_done;
  logic w_tmo;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && cmd_valid;
  assign w_done   = (r_state == ACCESS) && pready;
  // pready wins over an expiring counter
  assign w_tmo    = (r_state == ACCESS) && !pready
                    && (r_wait == TMO);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) w_next = SETUP;
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (pready || w_tmo) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwakeup   = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      SETUP: begin
        psel    = 1'b1;
        pwakeup = 1'b1;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwakeup = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_pprot  <= '0;
    end else if (w_accept) begin
      r_paddr  <= cmd_addr;
      r_pwrite <= cmd_write;
      r_pwdata <= cmd_wdata;
      r_pstrb  <= cmd_write ? cmd_strb : '0;
      r_pprot  <= cmd_prot;
    end
  end

  // saturating wait counter; leaves ACCESS before it could wrap
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_wait <= '0;
    end else if (w_accept) begin
      r_wait <= '0;
    end else if ((r_state == ACCESS) && !pready
                 && (r_wait != TMO)) begin
      r_wait <= r_wait + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_tmo;
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
        r_rsp_err   <= pslverr;
        r_rsp_tmo   <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
        r_rsp_tmo   <= 1'b1;
      end
    end
  end

  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_tmo;

endmodule
